// File: rtl/ncl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ncl_pkg                                                   |
// | Purpose  : Dual-rail (NCL) encoding type, codes and helper functions |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ncl_pkg;

    typedef logic [1:0] dr_t;

    localparam dr_t DR_NULL = 2'b00;
    localparam dr_t DR_0    = 2'b01;
    localparam dr_t DR_1    = 2'b10;
    localparam dr_t DR_ILL  = 2'b11;

    function automatic logic dr_is_data(input dr_t x);
        return (x == DR_0) || (x == DR_1);
    endfunction

    function automatic logic dr_is_null(input dr_t x);
        return x == DR_NULL;
    endfunction

    function automatic logic dr_is_ill(input dr_t x);
        return x == DR_ILL;
    endfunction

    // Swapping the rails inverts a dual-rail bit at no logic cost.
    function automatic dr_t dr_inv(input dr_t x);
        return {x[0], x[1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ncl_add_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ncl_add_stage                                             |
// | Purpose  : One slice of the dual-rail adder with its DATA/NULL       |
// |            wavefront register. Optional macro: NCL_ADD_PIPE_SUB_EN   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ncl_add_stage
    import ncl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SW    = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rfd_i,
    input  logic [WIDTH-1:0] a_r0_i,
    input  logic [WIDTH-1:0] a_r1_i,
    input  logic [WIDTH-1:0] b_r0_i,
    input  logic [WIDTH-1:0] b_r1_i,
    input  logic [WIDTH-1:0] sum_r0_i,
    input  logic [WIDTH-1:0] sum_r1_i,
    input  logic [1:0]       c_i,
`ifdef NCL_ADD_PIPE_SUB_EN
    input  logic [1:0]       sub_i,
    output logic [1:0]       sub_o,
`endif
    output logic [WIDTH-1:0] a_r0_o,
    output logic [WIDTH-1:0] a_r1_o,
    output logic [WIDTH-1:0] b_r0_o,
    output logic [WIDTH-1:0] b_r1_o,
    output logic [WIDTH-1:0] sum_r0_o,
    output logic [WIDTH-1:0] sum_r1_o,
    output logic [1:0]       c_o,
    output logic             null_o
);

    localparam int LO = IDX * SW;
    localparam int HI = LO + SW;

    logic [WIDTH-1:0] a_r0_q, a_r1_q, b_r0_q, b_r1_q, sum_r0_q, sum_r1_q;
    logic [WIDTH-1:0] a_r0_d, a_r1_d, b_r0_d, b_r1_d, sum_r0_d, sum_r1_d;
    logic [1:0]       c_q, c_d;
`ifdef NCL_ADD_PIPE_SUB_EN
    logic [1:0]       sub_q, sub_d;
`endif

    logic w_all_data, w_all_null;
    logic w_sub, w_carry, w_bb, w_s;

    // Below LO the word carries finished sum bits; from LO up, raw operands.
    always_comb begin
        w_all_data = 1'b1;
        w_all_null = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < LO) begin
                w_all_data &= dr_is_data({sum_r1_i[i], sum_r0_i[i]});
                w_all_null &= dr_is_null({sum_r1_i[i], sum_r0_i[i]});
            end else begin
                w_all_data &= dr_is_data({a_r1_i[i], a_r0_i[i]}) &
                              dr_is_data({b_r1_i[i], b_r0_i[i]});
                w_all_null &= dr_is_null({a_r1_i[i], a_r0_i[i]}) &
                              dr_is_null({b_r1_i[i], b_r0_i[i]});
            end
        end
        w_all_data &= dr_is_data(c_i);
        w_all_null &= dr_is_null(c_i);
`ifdef NCL_ADD_PIPE_SUB_EN
        w_all_data &= dr_is_data(sub_i);
        w_all_null &= dr_is_null(sub_i);
`endif
    end

    always_comb begin
        a_r0_d   = a_r0_q;
        a_r1_d   = a_r1_q;
        b_r0_d   = b_r0_q;
        b_r1_d   = b_r1_q;
        sum_r0_d = sum_r0_q;
        sum_r1_d = sum_r1_q;
        c_d      = c_q;
`ifdef NCL_ADD_PIPE_SUB_EN
        sub_d    = sub_q;
`endif
        w_sub   = 1'b0;
        w_carry = 1'b0;
        w_bb    = 1'b0;
        w_s     = 1'b0;
        if (w_all_data && rfd_i) begin
            a_r0_d   = '0;
            a_r1_d   = '0;
            b_r0_d   = '0;
            b_r1_d   = '0;
            sum_r0_d = '0;
            sum_r1_d = '0;
`ifdef NCL_ADD_PIPE_SUB_EN
            w_sub = sub_i[1];
            sub_d = sub_i;
`endif
            // Subtract mode reads the B and carry rails swapped.
            w_carry = w_sub ? c_i[0] : c_i[1];
            for (int i = 0; i < WIDTH; i++) begin
                if (i < LO) begin
                    sum_r0_d[i] = sum_r0_i[i];
                    sum_r1_d[i] = sum_r1_i[i];
                end else if (i >= HI) begin
                    a_r0_d[i] = a_r0_i[i];
                    a_r1_d[i] = a_r1_i[i];
                    b_r0_d[i] = b_r0_i[i];
                    b_r1_d[i] = b_r1_i[i];
                end else begin
                    w_bb        = w_sub ? b_r0_i[i] : b_r1_i[i];
                    w_s         = a_r1_i[i] ^ w_bb ^ w_carry;
                    w_carry     = (a_r1_i[i] & w_bb) | (w_carry & (a_r1_i[i] ^ w_bb));
                    sum_r1_d[i] = w_s;
                    sum_r0_d[i] = ~w_s;
                end
            end
            c_d = {w_carry, ~w_carry};
        end else if (w_all_null && !rfd_i) begin
            a_r0_d   = '0;
            a_r1_d   = '0;
            b_r0_d   = '0;
            b_r1_d   = '0;
            sum_r0_d = '0;
            sum_r1_d = '0;
            c_d      = DR_NULL;
`ifdef NCL_ADD_PIPE_SUB_EN
            sub_d    = DR_NULL;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r0_q   <= '0;
            a_r1_q   <= '0;
            b_r0_q   <= '0;
            b_r1_q   <= '0;
            sum_r0_q <= '0;
            sum_r1_q <= '0;
            c_q      <= DR_NULL;
`ifdef NCL_ADD_PIPE_SUB_EN
            sub_q    <= DR_NULL;
`endif
        end else begin
            a_r0_q   <= a_r0_d;
            a_r1_q   <= a_r1_d;
            b_r0_q   <= b_r0_d;
            b_r1_q   <= b_r1_d;
            sum_r0_q <= sum_r0_d;
            sum_r1_q <= sum_r1_d;
            c_q      <= c_d;
`ifdef NCL_ADD_PIPE_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    // Carry is DATA whenever the stage holds DATA, so it alone gives the phase.
    assign null_o   = (c_q == DR_NULL);
    assign a_r0_o   = a_r0_q;
    assign a_r1_o   = a_r1_q;
    assign b_r0_o   = b_r0_q;
    assign b_r1_o   = b_r1_q;
    assign sum_r0_o = sum_r0_q;
    assign sum_r1_o = sum_r1_q;
    assign c_o      = c_q;
`ifdef NCL_ADD_PIPE_SUB_EN
    assign sub_o    = sub_q;
`endif

endmodule
`default_nettype wire

// File: rtl/ncl_add_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ncl_add_pipe                                              |
// | Purpose  : Pipelined dual-rail ripple-carry adder with ko/ki         |
// |            handshake. Optional macro: NCL_ADD_PIPE_SUB_EN            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ncl_add_pipe
    import ncl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_r0,
    input  logic [WIDTH-1:0] a_r1,
    input  logic [WIDTH-1:0] b_r0,
    input  logic [WIDTH-1:0] b_r1,
`ifdef NCL_ADD_PIPE_SUB_EN
    input  logic [1:0]       sub_r,
`endif
    input  logic [1:0]       cin_r,
    output logic             ko,
    input  logic             ki,
    output logic [WIDTH-1:0] sum_r0,
    output logic [WIDTH-1:0] sum_r1,
    output logic [1:0]       cout_r,
    output logic             err
);

    localparam int SW = WIDTH / STAGES;

    // Index 0 is the port word; index k+1 is the register of stage k.
    logic [WIDTH-1:0] w_a_r0   [STAGES+1];
    logic [WIDTH-1:0] w_a_r1   [STAGES+1];
    logic [WIDTH-1:0] w_b_r0   [STAGES+1];
    logic [WIDTH-1:0] w_b_r1   [STAGES+1];
    logic [WIDTH-1:0] w_sum_r0 [STAGES+1];
    logic [WIDTH-1:0] w_sum_r1 [STAGES+1];
    logic [1:0]       w_c      [STAGES+1];
`ifdef NCL_ADD_PIPE_SUB_EN
    logic [1:0]       w_sub    [STAGES+1];
    assign w_sub[0] = sub_r;
`endif
    logic [STAGES-1:0] w_null;
    logic [STAGES-1:0] w_rfd;

    assign w_a_r0[0]   = a_r0;
    assign w_a_r1[0]   = a_r1;
    assign w_b_r0[0]   = b_r0;
    assign w_b_r1[0]   = b_r1;
    assign w_sum_r0[0] = '0;
    assign w_sum_r1[0] = '0;
    assign w_c[0]      = cin_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == STAGES - 1) begin : g_last
            assign w_rfd[k] = ki;
        end else begin : g_mid
            assign w_rfd[k] = w_null[k+1];
        end

        ncl_add_stage #(
            .WIDTH (WIDTH),
            .SW    (SW),
            .IDX   (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .rfd_i    (w_rfd[k]),
            .a_r0_i   (w_a_r0[k]),
            .a_r1_i   (w_a_r1[k]),
            .b_r0_i   (w_b_r0[k]),
            .b_r1_i   (w_b_r1[k]),
            .sum_r0_i (w_sum_r0[k]),
            .sum_r1_i (w_sum_r1[k]),
            .c_i      (w_c[k]),
`ifdef NCL_ADD_PIPE_SUB_EN
            .sub_i    (w_sub[k]),
            .sub_o    (w_sub[k+1]),
`endif
            .a_r0_o   (w_a_r0[k+1]),
            .a_r1_o   (w_a_r1[k+1]),
            .b_r0_o   (w_b_r0[k+1]),
            .b_r1_o   (w_b_r1[k+1]),
            .sum_r0_o (w_sum_r0[k+1]),
            .sum_r1_o (w_sum_r1[k+1]),
            .c_o      (w_c[k+1]),
            .null_o   (w_null[k])
        );
    end

    logic w_ill;
    logic err_q, err_d;

    always_comb begin
        w_ill = dr_is_ill(cin_r);
`ifdef NCL_ADD_PIPE_SUB_EN
        w_ill |= dr_is_ill(sub_r);
`endif
        for (int i = 0; i < WIDTH; i++) begin
            w_ill |= dr_is_ill({a_r1[i], a_r0[i]}) | dr_is_ill({b_r1[i], b_r0[i]});
        end
        err_d = err_q | w_ill;
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign ko     = w_null[0];
    assign sum_r0 = w_sum_r0[STAGES];
    assign sum_r1 = w_sum_r1[STAGES];
    assign cout_r = w_c[STAGES];
    assign err    = err_q;

endmodule
`default_nettype wire
